seg_scan_reader: RTL and testbench
==================================

# seg_scan_reader

Sampling decoder for a multiplexed seven-segment display bus: converts segment patterns (A..G, active-high) plus a one-hot digit select back into per-digit BCD codes. It sits on the display side of the watch controller for readback and self-check. Each digit is captured only after its pattern has been stable for a programmable number of samples. A pulse is raised once every digit has been freshly captured.

## Interface
- `DIGITS`, 4: number of multiplexed digit positions (1..8).
- `STABLE_CNT`, 4: number of consecutive identical samples required before a capture (1..15).
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: **synchronous, active-low reset**.
- `sample_en` input 1: sample strobe; the bus is evaluated only on cycles where it is high.
- `seg` input 7: segment lines, bit 6 = A … bit 0 = G, 1 = lit.
- `digit_sel` input DIGITS: one-hot digit select; bit i selects digit i.
- `clear` input 1: synchronous clear of captured data, valid bits and error flag.
- `digits_out` output 4*DIGITS: digit i occupies bits [4i+3:4i].
- `digit_valid` output DIGITS: bit i = digit i holds a valid decoded code.
- `invalid_pat` output 1: one-cycle pulse on capture of an unrecognised pattern.
- `err_sticky` output 1: set by any invalid capture; cleared only by reset or `clear`.
- `frame_done` output 1: one-cycle pulse when all digits have been captured since the last pulse.

## Operation
- Pattern map (ABCDEFG -> code):
  - 1111110 -> 0
  - 0110000 -> 1
  - 1101101 -> 2
  - 1111001 -> 3
  - 0110011 -> 4
  - 1011011 -> 5
  - 1011111 -> 6
  - 1110010 -> 7
  - 1111111 -> 8
  - 1111011 -> 9
  - 0000000 -> 4'hF (blank, valid)
  - any other pattern -> 4'hE (invalid)
- Internal state:
  - `last_sel`, `last_seg`: the previous sample.
  - `cnt`: 4-bit stability count.
  - `seen`: DIGITS-bit captured mask.
- Per sample (`sample_en`=1):
  - match = ({digit_sel, seg} == {last_sel, last_seg}).
  - cnt_next = match ? min(cnt+1, STABLE_CNT) : 1.
  - `last_*` is always updated to the current sample.
- Capture fires when cnt_next == STABLE_CNT and cnt != STABLE_CNT. It fires exactly once per stable period; a held pattern does not re-capture.
- On capture with `digit_sel` one-hot, digit i selected:
  - Valid pattern: `digits_out[i]` <= code, `digit_valid[i]` <= 1, `seen[i]` <= 1.
  - Invalid pattern: `digits_out[i]` <= 4'hE, `digit_valid[i]` <= 0, `seen[i]` <= 1, `invalid_pat` pulse, `err_sticky` <= 1.
- On capture with `digit_sel` zero or multi-hot: no digit is written and no flag changes.
- Frame completion: when the capture sets `seen` to all-ones, `frame_done` pulses and `seen` clears. `digits_out` and `digit_valid` are retained.
- `sample_en`=0 holds all state; no capture occurs.
- `clear`:
  - Zeroes `digits_out`, `digit_valid`, `seen` and `err_sticky`.
  - Resets cnt to 0.
  - Forces `invalid_pat` and `frame_done` low.
  - Has priority over a simultaneous capture.
- Reset values: all outputs 0; `last_sel`=0, `last_seg`=0, cnt=0, `seen`=0. Reset mid-stability discards the partial count.

## Timing
- Capture latency: the capturing sample's edge updates `digits_out`, `digit_valid` and `err_sticky`. `invalid_pat` and `frame_done` are high for exactly the following cycle.
- Minimum spacing between captures of the same digit: STABLE_CNT sampled cycles.
- STABLE_CNT=1: every changed sample captures immediately. A repeat of an identical sample does not re-capture.
- cnt saturates at STABLE_CNT and never wraps.
- A single differing sample restarts the count at 1. The next stable run needs STABLE_CNT samples in total, including that one.

## Test plan
- Reset with sample_en=1 throughout, STABLE_CNT=4, DIGITS=4:
  - Hold sel=0001, seg=0110000 for 4 samples -> `digits_out`[3:0]=1 and `digit_valid`=0001 after the 4th edge.
  - Hold 6 more samples -> no further capture.
- Scan sel 0001/0010/0100/1000, 4 samples each, with seg = codes 1, 2, 3, 4 -> `digits_out`=16'h4321, `digit_valid`=1111. `frame_done` high for exactly one cycle after the 16th sample, then `seen` is empty.
- sel=0010, seg=1010101 held 4 samples -> digit 1 = 4'hE, `digit_valid[1]`=0, `invalid_pat` one-cycle pulse, `err_sticky`=1 until `clear`.
- Glitch: 3 samples of code 5, 1 sample of code 6, then 3 samples of code 5 -> no capture.
  - A 4th code-5 sample after that -> capture of 5.
- sel=0000 and sel=0011 held 8 samples each -> no outputs change.
  - `clear` asserted on the same cycle as a capture -> all outputs 0.
- sample_en toggling 1/0 with a stable pattern -> capture after 4 enabled samples (7 cycles).
  - rst_n low after 3 matching samples -> count restarts from 0.

Source files
------------

// File: rtl/seg_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_reader
//  Purpose  : Reads a multiplexed seven-segment display bus back into BCD
//             codes, one nibble per digit position. A digit is captured only
//             after the bus has held the same select and pattern for
//             STABLE_CNT enabled samples. A pulse marks each completed frame,
//             meaning every digit has been captured once.
//  Ports    : clk          - clock, rising edge
//             rst_n        - synchronous active-low reset
//             sample_en    - sample strobe; the bus is evaluated only when high
//             seg[6:0]     - segments, bit 6 = A ... bit 0 = G, 1 = lit
//             digit_sel    - one-hot digit select
//             clear        - synchronous clear of captured data and flags
//             digits_out   - digit i in bits [4i+3:4i]; 4'hF = blank, 4'hE = bad
//             digit_valid  - digit i holds a recognised code
//             invalid_pat  - one-cycle pulse after an unrecognised capture
//             err_sticky   - set by any unrecognised capture
//             frame_done   - one-cycle pulse once all digits have been captured
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_reader #(
   parameter int DIGITS     = 4,
   parameter int STABLE_CNT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sample_en,
   input  logic [6:0]            seg,
   input  logic [DIGITS-1:0]     digit_sel,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   digits_out,
   output logic [DIGITS-1:0]     digit_valid,
   output logic                  invalid_pat,
   output logic                  err_sticky,
   output logic                  frame_done
);

   localparam logic [3:0] C_STABLE = 4'(STABLE_CNT);

   logic [DIGITS-1:0] last_sel;
   logic [6:0]        last_seg;
   logic [3:0]        cnt;
   logic [DIGITS-1:0] seen;

   logic              match;
   logic [3:0]        cnt_next;
   logic              capture;
   logic              sel_onehot;
   logic [3:0]        code;
   logic              code_ok;
   logic [DIGITS-1:0] seen_next;

   function automatic logic [3:0] decode(input logic [6:0] p);
      case (p)
         7'b1111110: decode = 4'd0;
         7'b0110000: decode = 4'd1;
         7'b1101101: decode = 4'd2;
         7'b1111001: decode = 4'd3;
         7'b0110011: decode = 4'd4;
         7'b1011011: decode = 4'd5;
         7'b1011111: decode = 4'd6;
         7'b1110010: decode = 4'd7;
         7'b1111111: decode = 4'd8;
         7'b1111011: decode = 4'd9;
         7'b0000000: decode = 4'hF;
         default:    decode = 4'hE;
      endcase
   endfunction

   always_comb begin
      match      = ({digit_sel, seg} == {last_sel, last_seg});
      // cnt never exceeds C_STABLE, so the saturation test also prevents wrap.
      cnt_next   = match ? ((cnt >= C_STABLE) ? C_STABLE : cnt + 4'd1) : 4'd1;
      // The !match term lets STABLE_CNT=1 capture every changed sample even
      // though the count is already sitting at 1 from the previous capture.
      capture    = sample_en && (cnt_next == C_STABLE) &&
                   ((cnt != C_STABLE) || !match);
      sel_onehot = (digit_sel != '0) &&
                   ((digit_sel & (digit_sel - DIGITS'(1))) == '0);
      code       = decode(seg);
      code_ok    = (code != 4'hE);
      seen_next  = seen | digit_sel;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_sel    <= '0;
         last_seg    <= '0;
         cnt         <= '0;
         seen        <= '0;
         digits_out  <= '0;
         digit_valid <= '0;
         invalid_pat <= 1'b0;
         err_sticky  <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         invalid_pat <= 1'b0;
         frame_done  <= 1'b0;

         if (sample_en) begin
            last_sel <= digit_sel;
            last_seg <= seg;
            cnt      <= cnt_next;
         end

         if (clear) begin
            digits_out  <= '0;
            digit_valid <= '0;
            seen        <= '0;
            err_sticky  <= 1'b0;
            cnt         <= '0;
         end else if (capture && sel_onehot) begin
            for (int i = 0; i < DIGITS; i++) begin
               if (digit_sel[i]) begin
                  digits_out[4*i +: 4] <= code;
                  digit_valid[i]       <= code_ok;
               end
            end
            if (!code_ok) begin
               invalid_pat <= 1'b1;
               err_sticky  <= 1'b1;
            end
            // Completing the mask closes the frame and starts a fresh one;
            // captured digits stay visible.
            if (seen_next == '1) begin
               frame_done <= 1'b1;
               seen       <= '0;
            end else begin
               seen <= seen_next;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_reader
//  Purpose  : Self-checking bench for seg_scan_reader (DIGITS=4, STABLE_CNT=4)
//             using a table of directed vectors plus a full-frame sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_reader;

   localparam logic [6:0] P0 = 7'b1111110;
   localparam logic [6:0] P1 = 7'b0110000;
   localparam logic [6:0] P2 = 7'b1101101;
   localparam logic [6:0] P3 = 7'b1111001;
   localparam logic [6:0] P4 = 7'b0110011;
   localparam logic [6:0] P5 = 7'b1011011;
   localparam logic [6:0] P6 = 7'b1011111;
   localparam logic [6:0] P7 = 7'b1110010;
   localparam logic [6:0] P8 = 7'b1111111;
   localparam logic [6:0] P9 = 7'b1111011;
   localparam logic [6:0] PB = 7'b0000000;
   localparam logic [6:0] PX = 7'b1010101;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_en = 1'b0;
   logic [6:0]  seg = '0;
   logic [3:0]  digit_sel = '0;
   logic        clear = 1'b0;
   logic [15:0] digits_out;
   logic [3:0]  digit_valid;
   logic        invalid_pat;
   logic        err_sticky;
   logic        frame_done;

   seg_scan_reader #(.DIGITS(4), .STABLE_CNT(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_en   (sample_en),
      .seg         (seg),
      .digit_sel   (digit_sel),
      .clear       (clear),
      .digits_out  (digits_out),
      .digit_valid (digit_valid),
      .invalid_pat (invalid_pat),
      .err_sticky  (err_sticky),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        en;
      logic        clr;
      logic [3:0]  sel;
      logic [6:0]  seg;
      logic [15:0] dig;
      logic [3:0]  val;
      logic        inv;
      logic        err;
      logic        fd;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic add(input int n, input logic r, input logic e, input logic c,
                      input logic [3:0] s, input logic [6:0] p,
                      input logic [15:0] d, input logic [3:0] v,
                      input logic i, input logic er, input logic f);
      vec_t t;
      t.rst_n = r; t.en = e; t.clr = c; t.sel = s; t.seg = p;
      t.dig = d; t.val = v; t.inv = i; t.err = er; t.fd = f;
      for (int k = 0; k < n; k++) vecs.push_back(t);
   endtask

   task automatic check(input string name, input int idx,
                        input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   int fd_cnt;
   int fd_at;
   int step;

   initial begin
      // ---------------- vector table ----------------
      add(1, 0,1,0, 4'b0001, P1, 16'h0000, 4'b0000, 0,0,0);   // in reset
      add(3, 1,1,0, 4'b0001, P1, 16'h0000, 4'b0000, 0,0,0);
      add(1, 1,1,0, 4'b0001, P1, 16'h0001, 4'b0001, 0,0,0);   // 4th: capture 1
      add(6, 1,1,0, 4'b0001, P1, 16'h0001, 4'b0001, 0,0,0);   // held: no re-capture
      add(3, 1,1,0, 4'b0010, P2, 16'h0001, 4'b0001, 0,0,0);
      add(1, 1,1,0, 4'b0010, P2, 16'h0021, 4'b0011, 0,0,0);
      add(3, 1,1,0, 4'b0100, P3, 16'h0021, 4'b0011, 0,0,0);
      add(1, 1,1,0, 4'b0100, P3, 16'h0321, 4'b0111, 0,0,0);
      add(3, 1,1,0, 4'b1000, P4, 16'h0321, 4'b0111, 0,0,0);
      add(1, 1,1,0, 4'b1000, P4, 16'h4321, 4'b1111, 0,0,1);   // frame done
      add(1, 1,1,0, 4'b1000, P4, 16'h4321, 4'b1111, 0,0,0);   // one cycle only
      add(3, 1,1,0, 4'b0010, PX, 16'h4321, 4'b1111, 0,0,0);
      add(1, 1,1,0, 4'b0010, PX, 16'h43E1, 4'b1101, 1,1,0);   // invalid capture
      add(1, 1,1,0, 4'b0010, PX, 16'h43E1, 4'b1101, 0,1,0);
      add(3, 1,1,0, 4'b0100, P5, 16'h43E1, 4'b1101, 0,1,0);   // glitch sequence
      add(1, 1,1,0, 4'b0100, P6, 16'h43E1, 4'b1101, 0,1,0);
      add(3, 1,1,0, 4'b0100, P5, 16'h43E1, 4'b1101, 0,1,0);
      add(1, 1,1,0, 4'b0100, P5, 16'h45E1, 4'b1101, 0,1,0);   // capture 5, no frame
      add(8, 1,1,0, 4'b0000, P1, 16'h45E1, 4'b1101, 0,1,0);   // no select
      add(8, 1,1,0, 4'b0011, P1, 16'h45E1, 4'b1101, 0,1,0);   // multi-hot
      add(3, 1,1,0, 4'b0001, P7, 16'h45E1, 4'b1101, 0,1,0);
      add(1, 1,1,1, 4'b0001, P7, 16'h0000, 4'b0000, 0,0,0);   // clear beats capture
      for (int k = 0; k < 3; k++) begin                        // 1/0 enable toggle
         add(1, 1,1,0, 4'b1000, P9, 16'h0000, 4'b0000, 0,0,0);
         add(1, 1,0,0, 4'b1000, P9, 16'h0000, 4'b0000, 0,0,0);
      end
      add(1, 1,1,0, 4'b1000, P9, 16'h9000, 4'b1000, 0,0,0);   // 7th cycle captures
      add(3, 1,1,0, 4'b0100, P0, 16'h9000, 4'b1000, 0,0,0);
      add(1, 0,1,0, 4'b0100, P0, 16'h0000, 4'b0000, 0,0,0);   // reset mid-count
      add(3, 1,1,0, 4'b0100, P0, 16'h0000, 4'b0000, 0,0,0);
      add(1, 1,1,0, 4'b0100, P0, 16'h0000, 4'b0100, 0,0,0);   // capture 0
      add(3, 1,1,0, 4'b0001, PB, 16'h0000, 4'b0100, 0,0,0);
      add(1, 1,1,0, 4'b0001, PB, 16'h000F, 4'b0101, 0,0,0);   // blank is valid

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst_n     = vecs[i].rst_n;
         sample_en = vecs[i].en;
         clear     = vecs[i].clr;
         digit_sel = vecs[i].sel;
         seg       = vecs[i].seg;
         @(posedge clk);
         #1;
         check("digits_out",  i, digits_out,          vecs[i].dig);
         check("digit_valid", i, {12'd0, digit_valid}, {12'd0, vecs[i].val});
         check("invalid_pat", i, {15'd0, invalid_pat}, {15'd0, vecs[i].inv});
         check("err_sticky",  i, {15'd0, err_sticky},  {15'd0, vecs[i].err});
         check("frame_done",  i, {15'd0, frame_done},  {15'd0, vecs[i].fd});
      end

      // ---------------- full frame with codes 6,7,8,9 ----------------
      @(negedge clk);
      sample_en = 1'b0;
      clear     = 1'b1;
      @(posedge clk);
      #1;
      check("clear_digits", 0, digits_out, 16'h0000);
      fd_cnt = 0;
      fd_at  = -1;
      step   = 0;
      for (int d = 0; d < 4; d++) begin
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            clear     = 1'b0;
            sample_en = 1'b1;
            digit_sel = 4'b0001 << d;
            case (d)
               0:       seg = P6;
               1:       seg = P7;
               2:       seg = P8;
               default: seg = P9;
            endcase
            @(posedge clk);
            #1;
            if (frame_done) begin
               fd_cnt++;
               fd_at = step;
            end
            step++;
         end
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         sample_en = 1'b0;
         @(posedge clk);
         #1;
         if (frame_done) fd_cnt++;
      end
      check("frame_pulses", 0, 16'(fd_cnt), 16'd1);
      check("frame_at",     0, 16'(fd_at),  16'd15);
      check("frame_digits", 0, digits_out, 16'h9876);
      check("frame_valid",  0, {12'd0, digit_valid}, 16'h000F);
      check("frame_err",    0, {15'd0, err_sticky},  16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
